// File: rtl/cp0_unit.sv
// cp0_unit: System Control Coprocessor (Status, Cause, EPC, Count, Compare, BadVAddr)
// at pipeline WB. Commits MTC0, serves MFC0 reads, takes exceptions/interrupts/ERET
// and drives the pipeline flush/redirect.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ext_int[NUM_HW_INT]         level interrupt lines (registered once before IP)
//   wb_valid/exception/exccode/bd/pc/badvaddr/eret/mtc0/cp0_addr/wdata
//                               WB-stage instruction information
//   rdata                       MFC0 read data (combinational, pre-edge values)
//   flush, flush_pc             pipeline flush and redirect target
//   int_pending                 an enabled interrupt is pending
module cp0_unit #(
    parameter int          NUM_HW_INT = 6,
    parameter int          TIMER_IP   = 7,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_HW_INT-1:0] ext_int,
    input  logic                  wb_valid,
    input  logic                  wb_exception,
    input  logic [4:0]            wb_exccode,
    input  logic                  wb_bd,
    input  logic [31:0]           wb_pc,
    input  logic [31:0]           wb_badvaddr,
    input  logic                  wb_eret,
    input  logic                  wb_mtc0,
    input  logic [ADDR_W-1:0]     wb_cp0_addr,
    input  logic [31:0]           wb_wdata,
    output logic [31:0]           rdata,
    output logic                  flush,
    output logic [31:0]           flush_pc,
    output logic                  int_pending
);

    localparam logic [ADDR_W-1:0] A_BADV   = ADDR_W'(8'h40);
    localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(8'h48);
    localparam logic [ADDR_W-1:0] A_CMP    = ADDR_W'(8'h58);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h60);
    localparam logic [ADDR_W-1:0] A_CAUSE  = ADDR_W'(8'h68);
    localparam logic [ADDR_W-1:0] A_EPC    = ADDR_W'(8'h70);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [NUM_HW_INT-1:0] r_ext_sync;
    logic                  r_ie;
    logic                  r_exl;
    logic [7:0]            r_im;
    logic [1:0]            r_ip_sw;
    logic                  r_bd;
    logic                  r_ti;
    logic [4:0]            r_exccode;
    logic [31:0]           r_epc;
    logic [31:0]           r_count;
    logic [31:0]           r_compare;
    logic [31:0]           r_badvaddr;
    logic [PW-1:0]         r_presc;

    logic [7:0]  w_ip;
    logic        w_int_pending;
    logic        w_take_int;
    logic        w_take_exc;
    logic        w_take_eret;
    logic        w_take_mtc0;
    logic        w_trap;
    logic        w_wr_count;
    logic        w_wr_cmp;
    logic        w_presc_wrap;
    logic        w_tick;
    logic [31:0] w_count_inc;

    // Hardware IP bits come from the synchronised lines; the timer shares one of them.
    always_comb begin
        w_ip = {6'b0, r_ip_sw};
        for (int k = 0; k < NUM_HW_INT; k++) begin
            w_ip[2+k] = r_ext_sync[k];
        end
        w_ip[TIMER_IP] = w_ip[TIMER_IP] | r_ti;
    end

    assign w_int_pending = (|(w_ip & r_im)) & r_ie & ~r_exl;

    // One event per cycle, strict priority: interrupt, exception, ERET, MTC0.
    assign w_take_int  = wb_valid & w_int_pending;
    assign w_take_exc  = wb_valid & ~w_int_pending & wb_exception;
    assign w_take_eret = wb_valid & ~w_int_pending & ~wb_exception & wb_eret;
    assign w_take_mtc0 = wb_valid & ~w_int_pending & ~wb_exception & ~wb_eret
                       & wb_mtc0;
    assign w_trap      = w_take_int | w_take_exc;

    assign w_wr_count   = w_take_mtc0 & (wb_cp0_addr == A_COUNT);
    assign w_wr_cmp     = w_take_mtc0 & (wb_cp0_addr == A_CMP);
    assign w_presc_wrap = (r_presc == PRESC_LAST);
    assign w_count_inc  = r_count + 32'd1;
    // A Count write suppresses the increment, and with it any timer match.
    assign w_tick       = w_presc_wrap & ~w_wr_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext_sync <= '0;
            r_ie       <= 1'b0;
            r_exl      <= 1'b0;
            r_im       <= 8'h00;
            r_ip_sw    <= 2'b00;
            r_bd       <= 1'b0;
            r_ti       <= 1'b0;
            r_exccode  <= 5'd0;
            r_epc      <= 32'd0;
            r_count    <= 32'd0;
            r_compare  <= 32'd0;
            r_badvaddr <= 32'd0;
            r_presc    <= '0;
        end else begin
            r_ext_sync <= ext_int;

            if (w_wr_count) begin
                r_count <= wb_wdata;
                r_presc <= '0;
            end else begin
                r_presc <= w_presc_wrap ? '0 : r_presc + PW'(1);
                if (w_presc_wrap) r_count <= w_count_inc;
            end

            if (w_wr_cmp) begin
                r_compare <= wb_wdata;
                r_ti      <= 1'b0;
            end else if (w_tick && (w_count_inc == r_compare)) begin
                r_ti <= 1'b1;
            end

            if (w_trap) begin
                // A nested trap keeps the original return point.
                if (!r_exl) begin
                    r_epc <= wb_bd ? wb_pc - 32'd4 : wb_pc;
                    r_bd  <= wb_bd;
                end
                r_exl     <= 1'b1;
                r_exccode <= w_take_int ? 5'd0 : wb_exccode;
                if (w_take_exc && (wb_exccode == 5'd4 || wb_exccode == 5'd5))
                    r_badvaddr <= wb_badvaddr;
            end else if (w_take_eret) begin
                r_exl <= 1'b0;
            end else if (w_take_mtc0) begin
                if (wb_cp0_addr == A_STATUS) begin
                    r_ie  <= wb_wdata[0];
                    r_exl <= wb_wdata[1];
                    r_im  <= wb_wdata[15:8];
                end
                if (wb_cp0_addr == A_CAUSE) r_ip_sw <= wb_wdata[9:8];
                if (wb_cp0_addr == A_EPC)   r_epc   <= wb_wdata;
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (wb_cp0_addr)
            A_BADV:   rdata = r_badvaddr;
            A_COUNT:  rdata = r_count;
            A_CMP:    rdata = r_compare;
            A_STATUS: rdata = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
            A_CAUSE:  rdata = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};
            A_EPC:    rdata = r_epc;
            default:  rdata = 32'd0;
        endcase
    end

    assign flush       = w_trap | w_take_eret;
    assign flush_pc    = w_take_eret ? r_epc : EXC_VECTOR;
    assign int_pending = w_int_pending;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed + randomized checks of cp0_unit against a
// behavioural model that tracks Count as elapsed-cycle arithmetic.
module tb_cp0_unit;

    localparam int          NHW = 6;
    localparam int          TIP = 7;
    localparam int          DIV = 2;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    localparam logic [7:0] A_BADV   = 8'h40;
    localparam logic [7:0] A_COUNT  = 8'h48;
    localparam logic [7:0] A_CMP    = 8'h58;
    localparam logic [7:0] A_STATUS = 8'h60;
    localparam logic [7:0] A_CAUSE  = 8'h68;
    localparam logic [7:0] A_EPC    = 8'h70;

    logic           clk;
    logic           rst;
    logic [NHW-1:0] ext_int;
    logic           wb_valid;
    logic           wb_exception;
    logic [4:0]     wb_exccode;
    logic           wb_bd;
    logic [31:0]    wb_pc;
    logic [31:0]    wb_badvaddr;
    logic           wb_eret;
    logic           wb_mtc0;
    logic [7:0]     wb_cp0_addr;
    logic [31:0]    wb_wdata;
    logic [31:0]    rdata;
    logic           flush;
    logic [31:0]    flush_pc;
    logic           int_pending;

    cp0_unit #(
        .NUM_HW_INT(NHW),
        .TIMER_IP  (TIP),
        .COUNT_DIV (DIV),
        .EXC_VECTOR(VEC),
        .ADDR_W    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ext_int     (ext_int),
        .wb_valid    (wb_valid),
        .wb_exception(wb_exception),
        .wb_exccode  (wb_exccode),
        .wb_bd       (wb_bd),
        .wb_pc       (wb_pc),
        .wb_badvaddr (wb_badvaddr),
        .wb_eret     (wb_eret),
        .wb_mtc0     (wb_mtc0),
        .wb_cp0_addr (wb_cp0_addr),
        .wb_wdata    (wb_wdata),
        .rdata       (rdata),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .int_pending (int_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Model state
    logic           m_ie, m_exl, m_bd, m_ti;
    logic [7:0]     m_im;
    logic [1:0]     m_ipsw;
    logic [4:0]     m_exc;
    logic [31:0]    m_epc, m_cmp, m_bad, m_base;
    logic [NHW-1:0] m_extq;
    longint         m_ticks;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_ticks / DIV);
    endfunction

    function automatic logic [7:0] m_ip();
        logic [7:0] ip;
        ip = {6'b0, m_ipsw};
        for (int k = 0; k < NHW; k++) ip[2+k] = m_extq[k];
        if (m_ti) ip[TIP] = 1'b1;
        return ip;
    endfunction

    function automatic logic m_ipend();
        return ((m_ip() & m_im) != 8'h00) && m_ie && !m_exl;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [7:0] a);
        case (a)
            A_BADV:   return m_bad;
            A_COUNT:  return m_count();
            A_CMP:    return m_cmp;
            A_STATUS: return 32'h0040_0000 | (32'(m_im) << 8)
                             | (32'(m_exl) << 1) | 32'(m_ie);
            A_CAUSE:  return (32'(m_bd) << 31) | (32'(m_ti) << 30)
                             | (32'(m_ip()) << 8) | (32'(m_exc) << 2);
            A_EPC:    return m_epc;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic m_kind(input int k);
        // k: 0 int, 1 exc, 2 eret, 3 mtc0
        logic ip;
        ip = wb_valid && m_ipend();
        case (k)
            0: return ip;
            1: return wb_valid && !ip && wb_exception;
            2: return wb_valid && !ip && !wb_exception && wb_eret;
            default: return wb_valid && !ip && !wb_exception && !wb_eret && wb_mtc0;
        endcase
    endfunction

    task automatic m_reset();
        m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0; m_im = 0; m_ipsw = 0;
        m_exc = 0; m_epc = 0; m_cmp = 0; m_bad = 0; m_base = 0;
        m_extq = '0; m_ticks = 0;
    endtask

    task automatic m_edge();
        logic ti_, ex_, er_, mt_, wr_cnt, wr_cmp, hit;
        if (rst) begin
            m_reset();
            return;
        end
        ti_ = m_kind(0); ex_ = m_kind(1); er_ = m_kind(2); mt_ = m_kind(3);
        wr_cnt = mt_ && wb_cp0_addr == A_COUNT;
        wr_cmp = mt_ && wb_cp0_addr == A_CMP;
        hit = 1'b0;
        if (wr_cnt) begin
            m_base = wb_wdata;
            m_ticks = 0;
        end else begin
            m_ticks++;
            hit = (m_ticks % DIV == 0) && (m_count() == m_cmp);
        end
        if (wr_cmp) begin
            m_cmp = wb_wdata;
            m_ti = 0;
        end else if (hit) m_ti = 1;
        if (ti_ || ex_) begin
            if (!m_exl) begin
                m_epc = wb_bd ? wb_pc - 4 : wb_pc;
                m_bd = wb_bd;
            end
            m_exl = 1;
            m_exc = ti_ ? 5'd0 : wb_exccode;
            if (ex_ && (wb_exccode == 4 || wb_exccode == 5)) m_bad = wb_badvaddr;
        end else if (er_) m_exl = 0;
        else if (mt_) begin
            if (wb_cp0_addr == A_STATUS) begin
                m_ie = wb_wdata[0];
                m_exl = wb_wdata[1];
                m_im = wb_wdata[15:8];
            end
            if (wb_cp0_addr == A_CAUSE) m_ipsw = wb_wdata[9:8];
            if (wb_cp0_addr == A_EPC) m_epc = wb_wdata;
        end
        m_extq = ext_int;
    endtask

    // Compare the DUT against the model, then advance one clock.
    task automatic tick();
        logic ef;
        #1;
        ef = m_kind(0) || m_kind(1) || m_kind(2);
        check("rdata", rdata, m_rdata(wb_cp0_addr));
        check("int_pending", 32'(int_pending), 32'(m_ipend()));
        if (!rst) begin
            check("flush", 32'(flush), 32'(ef));
            if (ef) check("flush_pc", flush_pc, m_kind(2) ? m_epc : VEC);
        end
        m_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        rst = 0; ext_int = '0; wb_valid = 0; wb_exception = 0; wb_exccode = 0;
        wb_bd = 0; wb_pc = 0; wb_badvaddr = 0; wb_eret = 0; wb_mtc0 = 0;
        wb_cp0_addr = 0; wb_wdata = 0;
    endtask

    task automatic mtc(input logic [7:0] a, input logic [31:0] d);
        set_idle();
        wb_valid = 1; wb_mtc0 = 1; wb_cp0_addr = a; wb_wdata = d;
        tick();
    endtask

    task automatic peek(input logic [7:0] a, input logic [31:0] mask,
                        input logic [31:0] exp, input string name);
        set_idle();
        wb_cp0_addr = a;
        #1;
        check(name, rdata & mask, exp);
    endtask

    logic [7:0] addr_tab [7];

    initial begin
        addr_tab = '{A_BADV, A_COUNT, A_CMP, A_STATUS, A_CAUSE, A_EPC, 8'h41};
        set_idle();
        rst = 1;
        @(negedge clk);
        m_reset();
        tick();
        rst = 0;

        peek(A_STATUS, 32'hFFFF_FFFF, 32'h0040_0000, "rst_status");
        check("rst_flush", 32'(flush), 0);
        check("rst_intp", 32'(int_pending), 0);
        peek(A_CAUSE, 32'hFFFF_FFFF, 0, "rst_cause");
        tick(); tick();
        peek(A_COUNT, 32'hFFFF_FFFF, 1, "count_1");
        tick(); tick();
        peek(A_COUNT, 32'hFFFF_FFFF, 2, "count_2");

        mtc(A_CMP, 5);
        mtc(A_STATUS, 32'h0000_8001);
        set_idle();
        repeat (4) tick();
        peek(A_CAUSE, 32'h4000_FF00, 32'h4000_8000, "ti_ip7");
        check("ti_intp", 32'(int_pending), 1);
        peek(A_COUNT, 32'hFFFF_FFFF, 5, "count_5");

        set_idle();
        wb_valid = 1; wb_pc = 32'hBFC0_0100;
        #1;
        check("int_flush", 32'(flush), 1);
        check("int_flush_pc", flush_pc, 32'hBFC0_0380);
        tick();
        peek(A_EPC, 32'hFFFF_FFFF, 32'hBFC0_0100, "int_epc");
        peek(A_CAUSE, 32'h0000_007C, 0, "int_exccode");
        set_idle();
        tick();
        peek(A_STATUS, 32'hFFFF_FFFF, 32'h0040_8003, "int_status");

        mtc(A_STATUS, 0);
        set_idle();
        wb_valid = 1; wb_exception = 1; wb_exccode = 4; wb_bd = 1;
        wb_pc = 32'h8000_0014; wb_badvaddr = 32'h1235;
        #1;
        check("exc_flush", 32'(flush), 1);
        check("exc_flush_pc", flush_pc, VEC);
        tick();
        peek(A_EPC, 32'hFFFF_FFFF, 32'h8000_0010, "exc_epc");
        peek(A_BADV, 32'hFFFF_FFFF, 32'h1235, "exc_badv");
        set_idle();
        tick();
        peek(A_CAUSE, 32'h8000_007C, 32'h8000_0010, "exc_bd_code");

        set_idle();
        wb_valid = 1; wb_exception = 1; wb_exccode = 5;
        wb_pc = 32'h8000_0040; wb_badvaddr = 32'h5678;
        tick();
        peek(A_EPC, 32'hFFFF_FFFF, 32'h8000_0010, "exl_epc_keep");
        peek(A_BADV, 32'hFFFF_FFFF, 32'h5678, "exl_badv");
        set_idle();
        tick();

        mtc(A_EPC, 32'h8000_0020);
        set_idle();
        wb_valid = 1; wb_eret = 1;
        #1;
        check("eret_flush", 32'(flush), 1);
        check("eret_pc", flush_pc, 32'h8000_0020);
        tick();
        peek(A_STATUS, 32'h0000_0002, 0, "eret_exl");

        mtc(A_CMP, 11);
        mtc(A_COUNT, 10);
        set_idle();
        tick();
        mtc(A_CMP, 11);
        peek(A_CAUSE, 32'h4000_0000, 0, "ti_beaten");
        peek(A_COUNT, 32'hFFFF_FFFF, 11, "count_11");

        mtc(A_COUNT, 32'hFFFF_FFFF);
        set_idle();
        tick(); tick();
        peek(A_COUNT, 32'hFFFF_FFFF, 0, "count_wrap");

        mtc(A_CAUSE, 32'h0000_0100);
        mtc(A_STATUS, 32'h0000_0101);
        peek(A_CAUSE, 32'h0000_FF00, 32'h0000_0100, "sw_ip0");
        check("sw_intp", 32'(int_pending), 1);
        set_idle();
        wb_valid = 1; wb_exception = 1; wb_exccode = 8; wb_mtc0 = 1;
        wb_cp0_addr = A_EPC; wb_wdata = 32'hDEAD_BEEF; wb_pc = 32'h8000_1000;
        #1;
        check("prio_flush", 32'(flush), 1);
        check("prio_flush_pc", flush_pc, VEC);
        tick();
        set_idle();
        wb_valid = 1;
        #1;
        check("single_flush", 32'(flush), 0);
        tick();
        peek(A_EPC, 32'hFFFF_FFFF, 32'h8000_1000, "prio_epc");
        peek(A_CAUSE, 32'h0000_007C, 0, "prio_exccode");
        set_idle();
        tick();

        for (int i = 0; i < 4000; i++) begin
            logic [NHW-1:0] keep_ext;
            keep_ext = ext_int;
            set_idle();
            ext_int = ($urandom_range(0, 19) == 0) ? NHW'($urandom) : keep_ext;
            rst = ($urandom_range(0, 399) == 0);
            wb_valid = ($urandom_range(0, 3) != 0);
            wb_exception = ($urandom_range(0, 11) == 0);
            wb_exccode = 5'($urandom);
            wb_bd = $urandom_range(0, 1) == 1;
            wb_pc = $urandom & 32'hFFFF_FFFC;
            wb_badvaddr = $urandom;
            wb_eret = ($urandom_range(0, 11) == 0);
            wb_mtc0 = ($urandom_range(0, 2) == 0);
            wb_cp0_addr = addr_tab[$urandom_range(0, 6)];
            wb_wdata = $urandom;
            if (wb_cp0_addr == A_CMP)
                wb_wdata = m_count() + 32'($urandom_range(0, 4));
            if (wb_cp0_addr == A_COUNT && $urandom_range(0, 1) == 1)
                wb_wdata = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
